// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite slave backed by a word-organised memory.
// Supports byte/halfword/word(/dword) transfers with little-endian lane
// selection, a fixed number of data-phase wait states, and the two-cycle
// ERROR response for out-of-range, over-wide or misaligned transfers.
module ahb_lite_slave_mem #(
    parameter int DATAWIDTH       = 32,
    parameter int ADDRWIDTH       = 32,
    parameter int SLAVE_ADDRWIDTH = 10,
    parameter int WAIT_STATES     = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 HSEL,
    input  logic [ADDRWIDTH-1:0] HADDR,
    input  logic [1:0]           HTRANS,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic [2:0]           HBURST,
    input  logic [DATAWIDTH-1:0] HWDATA,
    input  logic                 HREADY,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [DATAWIDTH-1:0] HRDATA
);

    localparam int BYTE_W    = DATAWIDTH / 8;
    localparam int LANE_BITS = $clog2(BYTE_W);
    localparam int MEM_ABITS = SLAVE_ADDRWIDTH + LANE_BITS;
    localparam int DEPTH     = 1 << SLAVE_ADDRWIDTH;

    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    // Counter preload: the first wait cycle already counts as one.
    localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t                 state;
    logic [2:0]             wait_cnt;
    logic                   pend_vld;     // a legal transfer is in its data phase
    logic                   pend_write;
    logic [MEM_ABITS-1:0]   addr_p;
    logic [2:0]             size_p;
    logic [DATAWIDTH-1:0]   mem [DEPTH];

    logic                   accept;
    logic                   legal;
    logic                   out_of_range;
    logic                   too_wide;
    logic                   misaligned;
    logic [ADDRWIDTH-1:0]   align_mask;
    logic [LANE_BITS-1:0]   lane_off;
    logic [SLAVE_ADDRWIDTH-1:0] word_idx;
    logic [BYTE_W-1:0]      byte_en;
    logic                   unused_ok;

    // HBURST carries no meaning for a memory slave.
    assign unused_ok = ^HBURST;

    // Address phase is only taken while this slave is itself ready, so
    // address-phase inputs seen during wait/ERR1 cycles are ignored.
    assign accept = HSEL && HREADY && HREADYOUT &&
                    ((HTRANS == TRANS_NONSEQ) || (HTRANS == TRANS_SEQ));

    assign out_of_range = (HADDR >> MEM_ABITS) != '0;
    assign too_wide     = (32'd1 << HSIZE) > 32'(BYTE_W);
    assign align_mask   = ADDRWIDTH'((32'd1 << HSIZE) - 32'd1);
    assign misaligned   = (HADDR & align_mask) != '0;
    assign legal        = !(out_of_range || too_wide || misaligned);

    assign lane_off = addr_p[LANE_BITS-1:0];
    assign word_idx = addr_p[MEM_ABITS-1:LANE_BITS];

    // Byte lanes covered by the registered transfer (little-endian).
    always_comb begin
        byte_en = '0;
        for (int b = 0; b < BYTE_W; b++) begin
            if ((b >= int'(lane_off)) && (b < int'(lane_off) + (1 << size_p))) begin
                byte_en[b] = 1'b1;
            end
        end
    end

    // Read data appears only in the completing cycle of a legal read;
    // the memory read is asynchronous so a write committed on the previous
    // edge is already visible.
    assign HRDATA = (pend_vld && !pend_write && HREADYOUT) ? mem[word_idx] : '0;

    // Transfer control: wait-state counting, error sequencing, ready/response.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            wait_cnt  <= 3'd0;
            pend_vld  <= 1'b0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ERR2: begin
                    state     <= ST_IDLE;
                    pend_vld  <= 1'b0;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    if (accept) begin
                        if (!legal) begin
                            state     <= ST_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                        end else begin
                            pend_vld <= 1'b1;
                            if (WAIT_STATES > 0) begin
                                state     <= ST_WAIT;
                                HREADYOUT <= 1'b0;
                                wait_cnt  <= WS_LOAD;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state     <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                end
            endcase
        end
    end

    // Capture address-phase attributes of each accepted legal transfer.
    always_ff @(posedge HCLK) begin
        if (accept && legal) begin
            addr_p     <= HADDR[MEM_ABITS-1:0];
            pend_write <= HWRITE;
            size_p     <= HSIZE;
        end
    end

    // Commit write data on the edge that ends the data phase.
    always_ff @(posedge HCLK) begin
        if (pend_vld && pend_write && HREADYOUT) begin
            for (int b = 0; b < BYTE_W; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/ahb_lite_slave_mem.md
AHB_LITE_SLAVE_MEM -- requirements
Module: ahb_lite_slave_mem

Interface
REQ-001 Parameter DATAWIDTH, default 32; data bus width, legal values 32 or 64.
REQ-002 Parameter ADDRWIDTH, default 32; HADDR width.
REQ-003 Parameter SLAVE_ADDRWIDTH, default 10; memory depth is 2^SLAVE_ADDRWIDTH words of DATAWIDTH bits.
REQ-004 Parameter WAIT_STATES, default 0; data-phase wait cycles per OKAY transfer, range 0..7.
REQ-005 HCLK  input  1  sole clock; all state updates on rising edge.
REQ-006 HRESETn  input  1  reset, asynchronous and active-low.
REQ-007 HSEL  input  1  slave select.
REQ-008 HADDR  input  ADDRWIDTH  byte address.
REQ-009 HTRANS  input  2  IDLE/BUSY/NONSEQ/SEQ encoding of the shared AHB package.
REQ-010 HWRITE  input  1  1=write, 0=read.
REQ-011 HSIZE  input  3  transfer size, BYTE=0, HALFWORD=1, WORD=2, WORD2=3.
REQ-012 HBURST  input  3  burst type; informational only.
REQ-013 HWDATA  input  DATAWIDTH  write data, valid in data phase.
REQ-014 HREADY  input  1  bus-level ready from interconnect.
REQ-015 HREADYOUT  output  1  slave ready.
REQ-016 HRESP  output  1  0=OKAY, 1=ERROR.
REQ-017 HRDATA  output  DATAWIDTH  read data.

Function
REQ-018 Address phase accepted when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; the block registers HADDR, HWRITE and HSIZE.
REQ-019 HTRANS IDLE or BUSY, or HSEL=0, with HREADY=1 yields a zero-wait OKAY data phase with no memory access.
REQ-020 FSM states are ST_IDLE, ST_WAIT, ST_ERR1 and ST_ERR2.
REQ-021 Accepted legal transfer with WAIT_STATES=0: stay in ST_IDLE with HREADYOUT=1 in the data phase.
REQ-022 Accepted legal transfer with WAIT_STATES>0: go to ST_WAIT; HREADYOUT=0 for exactly WAIT_STATES cycles (down-counter), then HREADYOUT=1 and return to ST_IDLE.
REQ-023 Illegal transfer cases: any HADDR bit above SLAVE_ADDRWIDTH+log2(DATAWIDTH/8)-1 set; 2^HSIZE exceeding DATAWIDTH/8; HADDR not aligned to 2^HSIZE.
REQ-024 Illegal transfer goes to ST_ERR1 (HREADYOUT=0, HRESP=1), then ST_ERR2 (HREADYOUT=1, HRESP=1), then ST_IDLE; no wait states are inserted.
REQ-025 Illegal transfers do not modify memory; HRDATA is 0 for illegal reads.
REQ-026 Write commits on the clock edge where the data phase completes (HREADYOUT=1); only byte lanes selected by registered address low bits and HSIZE are updated, little-endian.
REQ-027 Read drives the full addressed word on HRDATA in the completion cycle; non-selected lanes carry memory contents.
REQ-028 A read whose address phase coincides with a prior write's completing data phase to the same word returns the newly written data.
REQ-029 Address phase accepted in ST_ERR2 or at the last wait cycle (HREADY=1) is processed normally, giving back-to-back pipelining.
REQ-030 HRESP=0 in every state except ST_ERR1 and ST_ERR2.
REQ-031 While HREADYOUT=0, address-phase inputs are ignored.

Reset
REQ-032 HRESETn=0 immediately forces ST_IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, clears the wait counter and discards any pending transfer.
REQ-033 Memory contents are not reset.
REQ-034 First address phase is sampled on the first rising HCLK after HRESETn deasserts.

Verification
REQ-035 WAIT_STATES=0: write WORD 0xDEADBEEF @0x10, then read @0x10 -> HRDATA=0xDEADBEEF, HREADYOUT=1 throughout, HRESP=0.
REQ-036 Write WORD 0x11223344 @0x10, write BYTE 0xAB @0x13, read @0x10 -> 0xAB223344.
REQ-037 WAIT_STATES=2: read @0x20 -> HREADYOUT=0 for exactly 2 cycles, then 1 with valid data.
REQ-038 SLAVE_ADDRWIDTH=10, DATAWIDTH=32: write @0x1000, or HALFWORD @0x11 -> ERR1 (HREADYOUT=0, HRESP=1), ERR2 (1,1); memory unchanged.
REQ-039 INCR4 write @0x40 with one BUSY between beats 2 and 3, then INCR4 read -> BUSY gets zero-wait OKAY; 4 beats read back correct.
REQ-040 WAIT_STATES=3: HRESETn low during 2nd wait cycle of write @0x50 -> HREADYOUT=1, HRESP=0 asynchronously; @0x50 retains its prior value.
